// File: rtl/sensor_read_sequencer_pkg.sv
// Shared types and frame constants for the sensor read sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sensor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } seq_state_t;

    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 24;

    localparam logic READ_BIT    = 1'b1;
    localparam logic AUTOINC_BIT = 1'b1;

    // Command byte shifted out ahead of the data phase.
    function automatic logic [CMD_BITS-1:0] sensor_cmd(input logic [5:0] addr);
        return {READ_BIT, AUTOINC_BIT, addr};
    endfunction

endpackage

// File: rtl/sensor_read_sequencer_if.sv
// SPI pins plus the sample valid/ready stream of the sensor sequencer.
// Latency: n/a (wires only).
// Backpressure: sample_ready from the consumer holds sample_valid/sample_data.
interface sensor_read_sequencer_if;
    import sensor_seq_pkg::*;

    logic                 spi_sck;
    logic                 spi_cs_n;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic [DATA_BITS-1:0] sample_data;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, sample_data, sample_valid,
        input  spi_miso, sample_ready
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, sample_data, sample_valid,
        output spi_miso, sample_ready
    );

endinterface

// File: rtl/sensor_read_sequencer_spi_clk_gen.sv
// SCK phase generator: one-cycle rise/fall strobes every CLK_DIV clocks while run is high.
// Latency: first rise strobe CLK_DIV-1 cycles after run rises, fall strobe CLK_DIV later.
// Backpressure: none; dropping run restarts the bit at the low phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_rise_en,
    output logic o_fall_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap = i_run && (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Phase 0 is the SCK-low half of a bit, phase 1 the SCK-high half.
    assign o_rise_en = w_wrap && !r_phase;
    assign o_fall_en = w_wrap &&  r_phase;

endmodule

// File: rtl/sensor_read_sequencer.sv
// Periodic SPI mode-0 read of one 16-bit sensor sample into a valid/ready stream; optional overrun counter via SENSOR_SEQ_OVERRUN_CNT_EN.
// Latency: cs_n low 50*CLK_DIV cycles per frame; sample_valid rises in the cycle cs_n deasserts.
// Backpressure: an unconsumed sample is overwritten by the next frame and overrun pulses.
module sensor_read_sequencer
    import sensor_seq_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 10000,
    parameter logic [5:0] REG_ADDR      = 6'h32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    sensor_read_sequencer_if.master  bus,
    output logic                     busy,
    output logic                     overrun
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
    ,
    input  logic                     overrun_clr,
    output logic [7:0]               overrun_count
`endif
);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_CS_SETUP = CS_SETUP;
    localparam logic [1:0] ST_SHIFT    = SHIFT;
    localparam logic [1:0] ST_CS_HOLD  = CS_HOLD;

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    logic [1:0]            r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_pending;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit;
    logic [FRAME_BITS-1:0] r_tx;
    logic [DATA_BITS-1:0]  r_rx;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_sck;
    logic                  r_cs_n;

    logic w_tick;
    logic w_start;
    logic w_busy;
    logic w_cnt_done;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_tick     = enable && (r_timer == TW'(SAMPLE_PERIOD - 1));
    assign w_start    = !w_busy && (w_tick || r_pending);
    assign w_cnt_done = (r_cnt == CW'(CLK_DIV - 1));
    assign w_accept   = r_valid && bus.sample_ready;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (r_state == ST_SHIFT),
        .o_rise_en (w_rise),
        .o_fall_en (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Only one tick can be remembered while a frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (w_tick && w_busy) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_overrun <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_CS_SETUP;
                        r_cs_n  <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= {sensor_cmd(REG_ADDR), {DATA_BITS{1'b0}}};
                    end
                end
                ST_CS_SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[DATA_BITS-2:0], bus.spi_miso};
                    end
                    if (w_fall) begin
                        r_sck <= 1'b0;
                        r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        if (r_bit == BW'(FRAME_BITS - 1)) begin
                            r_state <= ST_CS_HOLD;
                            r_cnt   <= '0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (w_cnt_done) begin
                        // A load in an accept cycle replaces the consumed sample without overrun.
                        r_state   <= ST_IDLE;
                        r_cs_n    <= 1'b1;
                        r_data    <= r_rx;
                        r_valid   <= 1'b1;
                        r_overrun <= r_valid && !bus.sample_ready;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.spi_sck      = r_sck;
    assign bus.spi_cs_n     = r_cs_n;
    assign bus.spi_mosi     = r_tx[FRAME_BITS-1];
    assign bus.sample_data  = r_data;
    assign bus.sample_valid = r_valid;
    assign busy             = w_busy;
    assign overrun          = r_overrun;

`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= 8'd0;
        end else if (overrun_clr) begin
            r_ovr_cnt <= {7'd0, r_overrun};
        end else if (r_overrun && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_count = r_ovr_cnt;
`endif

endmodule
